vfp_config_regbank: RTL and testbench

Parametrised AXI4-Lite configuration register bank for the video frame processor (VFP) pipeline. It provides NUM_REGS user registers that are written from the processor side. With shadowing compiled in, new values reach the datapath only at a frame boundary, so no frame is processed with a half-updated configuration. It sits between the vfpconfig AXI4-Lite port and the VFP filter/colour stages, and generalises the fixed-size config slave to any register count and data width.

---
 rtl/generic_pack.sv | 17 +
 rtl/vfp_axi4l_slave_if.sv | 116 +++++++++++
 rtl/vfp_config_regbank.sv | 196 +++++++++++++++++++
 tb/tb_vfp_config_regbank.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/generic_pack.sv
// Shared word-index constants, AXI response codes and commit-state type
// for the VFP configuration register bank.
package generic_pack;

  localparam int IDX_CONTROL    = 0;
  localparam int IDX_REVISION   = 1;
  localparam int IDX_FIRST_USER = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } commit_state_t;

endpackage

// File: rtl/vfp_axi4l_slave_if.sv
// AXI4-Lite slave handshake engine: turns AW/W/B and AR/R channel traffic into
// single-cycle write and read strobes with word indices for the register bank.
module vfp_axi4l_slave_if
  import generic_pack::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int IDX_W      = ADDR_WIDTH - $clog2(DATA_WIDTH / 8)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  // write address / data / response
  input  logic [ADDR_WIDTH-1:0]     i_awaddr,
  input  logic                      i_awvalid,
  output logic                      o_awready,
  input  logic [DATA_WIDTH-1:0]     i_wdata,
  input  logic [DATA_WIDTH/8-1:0]   i_wstrb,
  input  logic                      i_wvalid,
  output logic                      o_wready,
  output logic [1:0]                o_bresp,
  output logic                      o_bvalid,
  input  logic                      i_bready,
  // read address / data
  input  logic [ADDR_WIDTH-1:0]     i_araddr,
  input  logic                      i_arvalid,
  output logic                      o_arready,
  output logic [DATA_WIDTH-1:0]     o_rdata,
  output logic [1:0]                o_rresp,
  output logic                      o_rvalid,
  input  logic                      i_rready,
  // register-bank side
  output logic                      o_wr_en,
  output logic [IDX_W-1:0]          o_wr_idx,
  output logic [DATA_WIDTH-1:0]     o_wr_data,
  output logic [DATA_WIDTH/8-1:0]   o_wr_strb,
  input  logic                      i_wr_err,
  output logic                      o_rd_en,
  output logic [IDX_W-1:0]          o_rd_idx,
  input  logic [DATA_WIDTH-1:0]     i_rd_data,
  input  logic                      i_rd_err
);

  localparam int LSB = $clog2(DATA_WIDTH / 8);

  logic                  r_aw_w_ready;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_arready;
  logic                  r_rvalid;
  logic [1:0]            r_rresp;
  logic [DATA_WIDTH-1:0] r_rdata;

  logic w_wr_hs;
  logic w_rd_hs;
  logic w_unused;

  assign w_wr_hs = r_aw_w_ready && i_awvalid && i_wvalid;
  assign w_rd_hs = r_arready && i_arvalid;

  // NOTE: every clocked register below is assigned with <= so that all of them
  // sample pre-edge values; a blocking = here would create ordering races.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_aw_w_ready <= 1'b0;
      r_bvalid     <= 1'b0;
      r_bresp      <= RESP_OKAY;
    end else begin
      // AW and W are accepted together only, and never while a response is owed
      r_aw_w_ready <= i_awvalid && i_wvalid && !r_bvalid && !r_aw_w_ready;
      if (w_wr_hs) begin
        r_bvalid <= 1'b1;
        r_bresp  <= i_wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (r_bvalid && i_bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= RESP_OKAY;
      r_rdata   <= '0;
    end else begin
      r_arready <= i_arvalid && !r_rvalid && !r_arready;
      if (w_rd_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= i_rd_data;
        r_rresp  <= i_rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (r_rvalid && i_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign o_awready = r_aw_w_ready;
  assign o_wready  = r_aw_w_ready;
  assign o_bvalid  = r_bvalid;
  assign o_bresp   = r_bresp;
  assign o_arready = r_arready;
  assign o_rvalid  = r_rvalid;
  assign o_rresp   = r_rresp;
  assign o_rdata   = r_rdata;

  assign o_wr_en   = w_wr_hs;
  assign o_wr_idx  = i_awaddr[ADDR_WIDTH-1:LSB];
  assign o_wr_data = i_wdata;
  assign o_wr_strb = i_wstrb;
  assign o_rd_en   = w_rd_hs;
  assign o_rd_idx  = i_araddr[ADDR_WIDTH-1:LSB];

  // byte-offset bits inside a word carry no meaning for this bank
  assign w_unused = ^{i_awaddr[LSB-1:0], i_araddr[LSB-1:0]};

endmodule

// File: rtl/vfp_config_regbank.sv
// Parametrised AXI4-Lite configuration register bank for the VFP pipeline.
// Define VFP_CFG_SHADOW_EN to double-buffer registers and commit them on frame_sof.
module vfp_config_regbank
  import generic_pack::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 8,
  parameter int          NUM_REGS   = 16,
  parameter logic [31:0] REVISION   = 32'h0000_0001
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic [ADDR_WIDTH-1:0]          vfpconfig_awaddr,
  input  logic [2:0]                     vfpconfig_awprot,
  input  logic                           vfpconfig_awvalid,
  output logic                           vfpconfig_awready,
  input  logic [DATA_WIDTH-1:0]          vfpconfig_wdata,
  input  logic [DATA_WIDTH/8-1:0]        vfpconfig_wstrb,
  input  logic                           vfpconfig_wvalid,
  output logic                           vfpconfig_wready,
  output logic [1:0]                     vfpconfig_bresp,
  output logic                           vfpconfig_bvalid,
  input  logic                           vfpconfig_bready,
  input  logic [ADDR_WIDTH-1:0]          vfpconfig_araddr,
  input  logic [2:0]                     vfpconfig_arprot,
  input  logic                           vfpconfig_arvalid,
  output logic                           vfpconfig_arready,
  output logic [DATA_WIDTH-1:0]          vfpconfig_rdata,
  output logic [1:0]                     vfpconfig_rresp,
  output logic                           vfpconfig_rvalid,
  input  logic                           vfpconfig_rready,
  input  logic                           frame_sof,
  output logic [NUM_REGS*DATA_WIDTH-1:0] cfg_active,
  output logic                           cfg_commit
);

  localparam int IDX_W  = ADDR_WIDTH - $clog2(DATA_WIDTH / 8);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS + IDX_FIRST_USER - 1);

  logic                  w_wr_en;
  logic [IDX_W-1:0]      w_wr_idx;
  logic [DATA_WIDTH-1:0] w_wr_data;
  logic [STRB_W-1:0]     w_wr_strb;
  logic                  w_wr_err;
  logic                  w_wr_user;
  logic                  w_rd_en;
  logic [IDX_W-1:0]      w_rd_idx;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_rd_err;
  logic                  w_pending;
  logic                  w_unused;

  logic [DATA_WIDTH-1:0] r_shadow [NUM_REGS];
  logic                  r_commit;

  vfp_axi4l_slave_if #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .IDX_W      (IDX_W)
  ) u_slave_if (
    .i_clk     (ACLK),
    .i_rst_n   (ARESETN),
    .i_awaddr  (vfpconfig_awaddr),
    .i_awvalid (vfpconfig_awvalid),
    .o_awready (vfpconfig_awready),
    .i_wdata   (vfpconfig_wdata),
    .i_wstrb   (vfpconfig_wstrb),
    .i_wvalid  (vfpconfig_wvalid),
    .o_wready  (vfpconfig_wready),
    .o_bresp   (vfpconfig_bresp),
    .o_bvalid  (vfpconfig_bvalid),
    .i_bready  (vfpconfig_bready),
    .i_araddr  (vfpconfig_araddr),
    .i_arvalid (vfpconfig_arvalid),
    .o_arready (vfpconfig_arready),
    .o_rdata   (vfpconfig_rdata),
    .o_rresp   (vfpconfig_rresp),
    .o_rvalid  (vfpconfig_rvalid),
    .i_rready  (vfpconfig_rready),
    .o_wr_en   (w_wr_en),
    .o_wr_idx  (w_wr_idx),
    .o_wr_data (w_wr_data),
    .o_wr_strb (w_wr_strb),
    .i_wr_err  (w_wr_err),
    .o_rd_en   (w_rd_en),
    .o_rd_idx  (w_rd_idx),
    .i_rd_data (w_rd_data),
    .i_rd_err  (w_rd_err)
  );

  assign w_wr_err  = (w_wr_idx > LAST_IDX);
  assign w_wr_user = w_wr_en && (w_wr_idx >= IDX_W'(IDX_FIRST_USER)) && !w_wr_err;

  // NOTE: the register file is reset like any other flop because its all-zero
  // state is architecturally visible on cfg_active straight out of reset.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int k = 0; k < NUM_REGS; k++) r_shadow[k] <= '0;
    end else if (w_wr_user) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (w_wr_idx == IDX_W'(k + IDX_FIRST_USER)) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (w_wr_strb[b]) r_shadow[k][b*8 +: 8] <= w_wr_data[b*8 +: 8];
          end
        end
      end
    end
  end

  // Reads see the shadow copy, so a same-edge write is not yet visible.
  // NOTE: every output of this block gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    w_rd_data = '0;
    w_rd_err  = 1'b0;
    if (w_rd_idx == IDX_W'(IDX_CONTROL)) begin
      w_rd_data[1] = w_pending;
    end else if (w_rd_idx == IDX_W'(IDX_REVISION)) begin
      w_rd_data = DATA_WIDTH'(REVISION);
    end else if (w_rd_idx > LAST_IDX) begin
      w_rd_err = 1'b1;
    end else begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (w_rd_idx == IDX_W'(k + IDX_FIRST_USER)) w_rd_data = r_shadow[k];
      end
    end
  end

`ifdef VFP_CFG_SHADOW_EN
  commit_state_t         r_state;
  commit_state_t         w_state_nxt;
  logic                  w_commit_req;
  logic                  w_copy;
  logic [DATA_WIDTH-1:0] r_active [NUM_REGS];

  assign w_commit_req = w_wr_en && (w_wr_idx == IDX_W'(IDX_CONTROL)) &&
                        w_wr_strb[0] && w_wr_data[0];

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // frame_sof in IDLE is ignored even alongside a request; that request waits
  // for the next frame, and requests while PENDING fold into the one copy.
  always_comb begin
    w_state_nxt = r_state;
    w_copy      = 1'b0;
    case (r_state)
      ST_IDLE:    if (w_commit_req) w_state_nxt = ST_PENDING;
      ST_PENDING: if (frame_sof) begin
        w_state_nxt = ST_IDLE;
        w_copy      = 1'b1;
      end
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int k = 0; k < NUM_REGS; k++) r_active[k] <= '0;
      r_commit <= 1'b0;
    end else begin
      if (w_copy) begin
        for (int k = 0; k < NUM_REGS; k++) r_active[k] <= r_shadow[k];
      end
      r_commit <= w_copy;
    end
  end

  assign w_pending = (r_state == ST_PENDING);

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_pack
    assign cfg_active[g*DATA_WIDTH +: DATA_WIDTH] = r_active[g];
  end

  assign w_unused = ^{w_rd_en, vfpconfig_awprot, vfpconfig_arprot};
`else
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_commit <= 1'b0;
    else          r_commit <= w_wr_user;
  end

  assign w_pending = 1'b0;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_pack
    assign cfg_active[g*DATA_WIDTH +: DATA_WIDTH] = r_shadow[g];
  end

  assign w_unused = ^{w_rd_en, vfpconfig_awprot, vfpconfig_arprot, frame_sof};
`endif

  assign cfg_commit = r_commit;

endmodule

// File: tb/tb_vfp_config_regbank.sv
// Directed self-checking bench for vfp_config_regbank (default parameters).
// Expectations follow VFP_CFG_SHADOW_EN when the bench is built with it.
module tb_vfp_config_regbank;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NR = 16;
`ifdef VFP_CFG_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic          frame_sof;
  logic [NR*DW-1:0] cfg_active;
  logic          cfg_commit;

  int n_cmp = 0;
  int n_err = 0;
  int n_commit = 0;
  int n_awrdy = 0;
  int rd_lat;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cfg_commit) n_commit++;
    if (awready)    n_awrdy++;
  end

  vfp_config_regbank dut (
    .ACLK              (clk),
    .ARESETN           (rst_n),
    .vfpconfig_awaddr  (awaddr),
    .vfpconfig_awprot  (awprot),
    .vfpconfig_awvalid (awvalid),
    .vfpconfig_awready (awready),
    .vfpconfig_wdata   (wdata),
    .vfpconfig_wstrb   (wstrb),
    .vfpconfig_wvalid  (wvalid),
    .vfpconfig_wready  (wready),
    .vfpconfig_bresp   (bresp),
    .vfpconfig_bvalid  (bvalid),
    .vfpconfig_bready  (bready),
    .vfpconfig_araddr  (araddr),
    .vfpconfig_arprot  (arprot),
    .vfpconfig_arvalid (arvalid),
    .vfpconfig_arready (arready),
    .vfpconfig_rdata   (rdata),
    .vfpconfig_rresp   (rresp),
    .vfpconfig_rvalid  (rvalid),
    .vfpconfig_rready  (rready),
    .frame_sof         (frame_sof),
    .cfg_active        (cfg_active),
    .cfg_commit        (cfg_commit)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                           input logic [3:0] strb, input bit hold_b,
                           output logic [1:0] resp);
    int cyc;
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = !hold_b;
    cyc = 0;
    while (!awready && cyc < 20) begin @(negedge clk); cyc++; end
    check("wr_ready", {awready, wready}, 2'b11);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    cyc = 0;
    while (!bvalid && cyc < 20) begin @(negedge clk); cyc++; end
    check("wr_bvalid", bvalid, 1'b1);
    resp = bresp;
    if (!hold_b) begin
      @(negedge clk);
      bready = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                          output logic [1:0] resp);
    int cyc;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    cyc = 0;
    while (!arready && cyc < 20) begin @(negedge clk); cyc++; end
    check("rd_arready", arready, 1'b1);
    rd_lat = cyc;
    @(negedge clk);
    arvalid = 1'b0;
    cyc = 0;
    while (!rvalid && cyc < 20) begin @(negedge clk); cyc++; end
    check("rd_rvalid", rvalid, 1'b1);
    rd_lat = rd_lat + 1 + cyc;
    data = rdata;
    resp = rresp;
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic pulse_sof();
    @(negedge clk);
    frame_sof = 1'b1;
    @(negedge clk);
    frame_sof = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp;
    logic [DW-1:0] data;
    int c0, a0, nb, cyc;

    rst_n = 1'b0;
    awaddr = '0; awprot = 3'b000; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = 3'b000; arvalid = 1'b0; rready = 1'b0;
    frame_sof = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_ready", {awready, wready, arready}, 3'b000);
    check("rst_valid", {bvalid, rvalid}, 2'b00);
    check("rst_resp", {bresp, rresp}, 4'b0000);
    check("rst_rdata", rdata, 32'h0);
    check("rst_commit", cfg_commit, 1'b0);
    check("rst_active", cfg_active, '0);
    rst_n = 1'b1;

    // revision and an empty user register
    axi_read(8'h04, data, resp);
    check("rev_data", data, 32'h0000_0001);
    check("rev_resp", resp, 2'b00);
    check("rd_latency", rd_lat, 2);
    axi_read(8'h08, data, resp);
    check("reg0_init", data, 32'h0);

    // byte-lane write to reg1
    axi_write(8'h0C, 32'hA5A5_1234, 4'b0101, 1'b0, resp);
    check("reg1_bresp", resp, 2'b00);
    axi_read(8'h0C, data, resp);
    check("reg1_strb", data, 32'h00A5_0034);
    check("reg1_active", cfg_active[1*DW +: DW], SHADOW ? 32'h0 : 32'h00A5_0034);
    axi_read(8'h0D, data, resp);
    check("reg1_lowaddr", data, 32'h00A5_0034);

    // reg0 write, commit request, frame boundary
    c0 = n_commit;
    axi_write(8'h08, 32'h0000_0011, 4'hF, 1'b0, resp);
    repeat (2) @(negedge clk);
    check("wr_commit_cnt", n_commit - c0, SHADOW ? 0 : 1);
    check("reg0_pre", cfg_active[0 +: DW], SHADOW ? 32'h0 : 32'h11);
    axi_write(8'h00, 32'h0000_0001, 4'h1, 1'b0, resp);
    axi_read(8'h00, data, resp);
    check("ctrl_pending", data, SHADOW ? 32'h2 : 32'h0);
    c0 = n_commit;
    pulse_sof();
    check("sof_commit_cnt", n_commit - c0, SHADOW ? 1 : 0);
    check("reg0_active", cfg_active[0 +: DW], 32'h11);
    check("reg1_commit", cfg_active[1*DW +: DW], 32'h00A5_0034);
    axi_read(8'h00, data, resp);
    check("ctrl_idle", data, 32'h0);

    // out-of-range, last user register, revision write
    axi_write(8'h48, 32'hDEAD_BEEF, 4'hF, 1'b0, resp);
    check("oor_bresp", resp, 2'b10);
    axi_read(8'h48, data, resp);
    check("oor_rdata", data, 32'h0);
    check("oor_rresp", resp, 2'b10);
    axi_read(8'h08, data, resp);
    check("oor_nochange", data, 32'h11);
    axi_write(8'h44, 32'h1357_9BDF, 4'hF, 1'b0, resp);
    check("last_bresp", resp, 2'b00);
    axi_read(8'h44, data, resp);
    check("last_data", data, 32'h1357_9BDF);
    axi_read(8'hFC, data, resp);
    check("idx63_rresp", resp, 2'b10);
    axi_write(8'h04, 32'hFFFF_FFFF, 4'hF, 1'b0, resp);
    check("rev_wr_bresp", resp, 2'b00);
    axi_read(8'h04, data, resp);
    check("rev_wr_keep", data, 32'h0000_0001);

    // AW three cycles ahead of W, bready held low for 5 cycles
    a0 = n_awrdy;
    @(negedge clk);
    awaddr = 8'h10; wdata = 32'h0000_CAFE; wstrb = 4'hF;
    awvalid = 1'b1; bready = 1'b0;
    repeat (3) @(negedge clk);
    check("aw_only_wait", awready, 1'b0);
    wvalid = 1'b1;
    cyc = 0;
    while (!awready && cyc < 20) begin @(negedge clk); cyc++; end
    check("aw_w_ready", wready, 1'b1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    nb = 0;
    repeat (5) begin
      if (bvalid && bresp == 2'b00) nb++;
      @(negedge clk);
    end
    check("bvalid_hold", nb, 5);
    bready = 1'b1;
    @(negedge clk);
    check("bvalid_drop", bvalid, 1'b0);
    bready = 1'b0;
    check("awready_pulses", n_awrdy - a0, 1);
    axi_read(8'h10, data, resp);
    check("reg2_data", data, 32'h0000_CAFE);

    // read and write of reg2 on the same edge
    @(negedge clk);
    awaddr = 8'h10; wdata = 32'h0000_BEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 8'h10; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    check("same_edge_ready", {awready, arready}, 2'b11);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    check("same_edge_rvalid", rvalid, 1'b1);
    check("same_edge_old", rdata, 32'h0000_CAFE);
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    axi_read(8'h10, data, resp);
    check("same_edge_new", data, 32'h0000_BEEF);

    // reset while a response is owed and a commit is pending
    axi_write(8'h08, 32'h0000_0022, 4'hF, 1'b0, resp);
    axi_write(8'h00, 32'h0000_0001, 4'h1, 1'b1, resp);
    check("pre_rst_active", cfg_active[0 +: DW], SHADOW ? 32'h11 : 32'h22);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_bvalid", bvalid, 1'b0);
    check("mid_rst_active", cfg_active, '0);
    @(negedge clk);
    bready = 1'b0;
    rst_n = 1'b1;
    axi_read(8'h00, data, resp);
    check("post_rst_ctrl", data, 32'h0);
    axi_read(8'h08, data, resp);
    check("post_rst_reg0", data, 32'h0);
    c0 = n_commit;
    pulse_sof();
    check("post_rst_commit", n_commit - c0, 0);
    check("post_rst_active", cfg_active, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
